// File: rtl/shared_bus_rr_arbiter.sv
// Round-robin arbiter for M devices sharing one registered N-bit bus, with bounded
// ownership, a one-cycle turnaround and broadcast of every beat to all non-owners.
module shared_bus_rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 4,
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned IdW     = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     req,
    input  logic [M*N-1:0]   data_in,
    output logic [M-1:0]     grant,
    output logic [IdW-1:0]   owner_id,
    output logic [N-1:0]     bus,
    output logic             bus_valid,
    output logic [M*N-1:0]   data_out,
    output logic [M-1:0]     rx_valid
);

    localparam int unsigned   CntW     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e            state_q, state_d;
    logic [M-1:0]      grant_q, grant_d;
    logic [IdW-1:0]    owner_q, owner_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]      bus_q, bus_d;
    logic              bus_valid_q, bus_valid_d;
    logic [M*N-1:0]    dout_q, dout_d;
    logic [M-1:0]      rx_q, rx_d;

    logic              pick_found;
    logic [IdW-1:0]    pick_idx;
    logic [N-1:0]      own_data;
    logic              others_pending;

    // Scan starts just after the last owner, so it ends up with lowest priority.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        idx        = 0;
        for (int unsigned i = 1; i <= M; i++) begin
            idx = (32'(ptr_q) + i) % M;
            if (!pick_found && req[IdW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(idx);
            end
        end
    end

    assign own_data       = data_in[32'(owner_q)*N +: N];
    assign others_pending = |(req & ~grant_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        bus_valid_d = 1'b0;
        dout_d      = dout_q;
        rx_d        = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StOwn;
                    grant_d = M'(1) << pick_idx;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            StOwn: begin
                if (!req[owner_q]) begin
                    state_d = StIdle;
                    grant_d = '0;
                end else begin
                    bus_d       = own_data;
                    bus_valid_d = 1'b1;
                    for (int j = 0; j < M; j++) begin
                        if (IdW'(j) != owner_q) begin
                            dout_d[j*N +: N] = own_data;
                            rx_d[j]          = 1'b1;
                        end
                    end
                    // Last allowed beat with a competitor waiting: emit it, then release.
                    if (cnt_q == HoldLast && others_pending) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end else if (cnt_q != HoldLast) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= IdW'(M - 1);
            cnt_q       <= '0;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
            dout_q      <= '0;
            rx_q        <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
            dout_q      <= dout_d;
            rx_q        <= rx_d;
        end
    end

    assign grant     = grant_q;
    assign owner_id  = owner_q;
    assign bus       = bus_q;
    assign bus_valid = bus_valid_q;
    assign data_out  = dout_q;
    assign rx_valid  = rx_q;

endmodule
